pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Variable-amount, multi-mode shifter for the arithmetic/pipelining track: logical left, logical right, arithmetic right and rotate right of an N-bit word by 0..N-1 bits.
- Logarithmic structure: one register stage per shift-amount bit, stage k applies a shift of 2^k.
- Valid/ready streaming on both sides, full throughput of one word per clock.
- Sits between an operand source and a result consumer in the datapath exercises.

Parameters:
- N, 8, data width; power of two, >= 2.
- SW, $clog2(N), shift-amount width. Derived; do not override.
- STAGES, SW, pipeline depth and latency in cycles. Derived.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- up_valid  in  1  input word present.
- up_ready  out  1  block accepts input this cycle.
- up_data  in  N  operand, unsigned except in SRA mode.
- up_shamt  in  SW  shift amount, 0..N-1.
- up_op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- down_valid  out  1  result present.
- down_ready  in  1  consumer accepts result.
- down_data  out  N  shifted result.

Behaviour:
- Reset, when rst_n = 0 at a clock edge:
  - All stage valid bits are cleared, so down_valid = 0 on the next cycle.
  - All data, shamt and op registers are cleared to 0, so down_data = 0.
  - up_ready is combinational and equals 1 while the pipe is empty.
- Reset mid-operation: all in-flight words are discarded. No partial output.
- Global advance enable: en = down_ready | ~down_valid.
  - up_ready = en.
  - Input is accepted on an edge where up_valid & up_ready.
  - When en = 0, every stage register holds, including valid bits.
- Stage registers: each stage carries valid, data, remaining shamt bits and op.
  - Stage k is loaded from stage k-1, or from the up_* inputs for k = 0, when en = 1.
  - The valid bit propagates as-is, so bubbles are preserved. No bubble collapsing.
- Stage k function: if shamt[k] = 1, shift the incoming data by 2^k per op, else pass through.
  - SLL: zero fill at the LSB end.
  - SRL: zero fill at the MSB end.
  - SRA: MSB fill, using the sign of the original operand; the sign is preserved because each stage replicates the current MSB.
  - ROR: bits leaving the LSB end re-enter at the MSB end.
- Result: down_data equals the full shift of the accepted up_data by up_shamt. All results are N bits, no width growth.
  - SLL discards bits shifted out.
  - shamt = 0 passes the operand unchanged in all modes.
- Latency: a word accepted at edge t appears with down_valid = 1 after edge t+STAGES-1, i.e. STAGES registers, provided en stayed 1.
- Backpressure: while down_valid & ~down_ready, down_data and down_valid must stay stable and up_ready = 0.
- Ordering: strictly in order; no word is dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal and sustains 1 word per clock.
- up_data, up_shamt and up_op are don't-care when up_valid = 0.

Test Plan:
- Reset check: hold rst_n = 0 for 2 cycles with up_valid = 1 -> down_valid = 0, down_data = 0. After release, the first accepted word emerges after exactly 3 edges (N = 8).
- Mode sweep, N = 8, up_data = 0xB6, shamt = 3, down_ready = 1 -> SLL = 0xB0, SRL = 0x16, SRA = 0xF6, ROR = 0xD6, on consecutive cycles in issue order.
- Boundaries: 0xB6 with shamt 0 -> 0xB6 in all modes. 0x80 SRA by 7 -> 0xFF. 0x80 SRL by 7 -> 0x01. 0x01 SLL by 7 -> 0x80. 0x01 ROR by 1 -> 0x80.
- Backpressure: stream 6 words back-to-back and drop down_ready for 4 cycles mid-stream -> up_ready = 0 during the stall, down_data held stable, all 6 results in order, none lost.
- Bubbles: toggle up_valid 1,0,1,0 with down_ready = 1 -> down_valid shows the same 1,0,1,0 pattern delayed by 3 cycles.
- Mid-flight reset: accept 3 words, assert rst_n = 0 for 1 cycle -> none of the 3 words ever appear on the output. A new word issued after release appears with normal latency.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log-depth streaming SLL/SRL/SRA/ROR shifter, one register stage per shift-amount bit
module pipelined_barrel_shifter #(
  parameter int N = 8,
  localparam int SW = $clog2(N),
  localparam int STAGES = SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shamt,
  input  logic [1:0]    up_op,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);
  logic          en;
  logic          valid_q [STAGES];
  logic [N-1:0]  data_q  [STAGES];
  logic [SW-1:0] shamt_q [STAGES];
  logic [1:0]    op_q    [STAGES];
  assign down_valid = valid_q[STAGES-1];
  assign down_data = data_q[STAGES-1];
  assign en = down_ready | ~down_valid;
  assign up_ready = en;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int S = 1 << k;
    logic          v_in;
    logic [N-1:0]  d_in;
    logic [N-1:0]  d_out;
    logic [SW-1:0] s_in;
    logic [1:0]    o_in;
    if (k == 0) begin : g_head
      assign v_in = up_valid;
      assign d_in = up_data;
      assign s_in = up_shamt;
      assign o_in = up_op;
    end else begin : g_tail
      assign v_in = valid_q[k-1];
      assign d_in = data_q[k-1];
      assign s_in = shamt_q[k-1];
      assign o_in = op_q[k-1];
    end
    // shift by 2^k when the lowest remaining amount bit is set; SRA copies the current MSB, which still holds the operand sign
    always_comb
      d_out = !s_in[0]       ? d_in :
              o_in == 2'b00  ? {d_in[N-1-S:0], {S{1'b0}}} :
              o_in == 2'b01  ? {{S{1'b0}}, d_in[N-1:S]} :
              o_in == 2'b10  ? {{S{d_in[N-1]}}, d_in[N-1:S]} :
                               {d_in[S-1:0], d_in[N-1:S]};
    // valid and data advance together under the global enable; bubbles travel as-is
    always_ff @(posedge clk)
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        data_q[k] <= '0;
      end else if (en) begin
        valid_q[k] <= v_in;
        data_q[k] <= d_out;
      end
    if (k < STAGES - 1) begin : g_fwd
      // hand the still-unused amount bits and the mode to the next stage, consumed bit dropped
      always_ff @(posedge clk)
        if (!rst_n) begin
          shamt_q[k] <= '0;
          op_q[k] <= '0;
        end else if (en) begin
          shamt_q[k] <= s_in >> 1;
          op_q[k] <= o_in;
        end
    end
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: scoreboard bench for the pipelined barrel shifter
module tb_pipelined_barrel_shifter;
  localparam int N = 8;
  logic clk = 0;
  logic rst_n = 0;
  logic up_valid = 0;
  logic up_ready;
  logic [N-1:0] up_data = '0;
  logic [2:0] up_shamt = '0;
  logic [1:0] up_op = '0;
  logic down_valid;
  logic down_ready = 1;
  logic [N-1:0] down_data;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit done = 0;
  logic [N-1:0] sb [$];
  logic dv_hist [0:4095];
  logic prev_stall = 0;
  logic [N-1:0] prev_data = '0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_shamt(up_shamt), .up_op(up_op),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [N-1:0] d, input int s, input logic [1:0] op);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      case (op)
        2'b00: r[i] = (i >= s) ? d[i-s] : 1'b0;
        2'b01: r[i] = (i + s < N) ? d[i+s] : 1'b0;
        2'b10: r[i] = (i + s < N) ? d[i+s] : d[N-1];
        default: r[i] = d[(i+s)%N];
      endcase
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cyc < 4096) dv_hist[cyc] = down_valid;
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", 32'(down_valid), 1);
        check("hold_data", 32'(down_data), 32'(prev_data));
      end
      if (down_valid && !down_ready) check("stall_up_ready", 32'(up_ready), 0);
      if (down_valid && down_ready) begin
        if (sb.size() == 0) check("spurious_out", 32'(down_data), 32'hDEAD);
        else check("result", 32'(down_data), 32'(sb.pop_front()));
      end
    end
    prev_stall = rst_n && down_valid && !down_ready;
    prev_data = down_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic [2:0] s, input logic [1:0] op, input logic [N-1:0] exp);
    bit ok = 0;
    up_valid = 1; up_data = d; up_shamt = s; up_op = op;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = up_ready;
      @(posedge clk);
      #1;
    end
    up_valid = 0;
    if (ok) begin
      sb.push_back(exp);
      acc_cyc = cyc;
    end else check("accept_timeout", 0, 1);
  endtask

  task automatic send_m(input logic [N-1:0] d, input logic [2:0] s, input logic [1:0] op);
    send(d, s, op, model(d, int'(s), op));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++) tick(1);
    tick(4);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    up_valid = 1; up_data = 8'hB6; up_shamt = 3'd3;
    tick(2);
    check("rst_down_valid", 32'(down_valid), 0);
    check("rst_down_data", 32'(down_data), 0);
    check("rst_up_ready", 32'(up_ready), 1);
    up_valid = 0; rst_n = 1;
    send(8'h5A, 3'd1, 2'b00, 8'hB4);
    e0 = acc_cyc;
    tick(3);
    check("lat_not_early", 32'(dv_hist[e0+1]), 0);
    check("lat_exact", 32'(dv_hist[e0+2]), 1);
    drain();
    send(8'hB6, 3'd3, 2'b00, 8'hB0);
    send(8'hB6, 3'd3, 2'b01, 8'h16);
    send(8'hB6, 3'd3, 2'b10, 8'hF6);
    send(8'hB6, 3'd3, 2'b11, 8'hD6);
    drain();
    for (int op = 0; op < 4; op++) send(8'hB6, 3'd0, 2'(op), 8'hB6);
    send(8'h80, 3'd7, 2'b10, 8'hFF);
    send(8'h80, 3'd7, 2'b01, 8'h01);
    send(8'h01, 3'd7, 2'b00, 8'h80);
    send(8'h01, 3'd1, 2'b11, 8'h80);
    drain();
    send_m(8'h11, 3'd2, 2'b11);
    e0 = acc_cyc;
    tick(1);
    send_m(8'h93, 3'd5, 2'b10);
    tick(5);
    check("bubble_0", 32'(dv_hist[e0+2]), 1);
    check("bubble_1", 32'(dv_hist[e0+3]), 0);
    check("bubble_2", 32'(dv_hist[e0+4]), 1);
    check("bubble_3", 32'(dv_hist[e0+5]), 0);
    drain();
    fork
      for (int i = 0; i < 6; i++) send_m(8'(8'h3C + 8'(i * 37)), 3'(i + 1), 2'(i));
      begin
        tick(2);
        down_ready = 0;
        tick(4);
        down_ready = 1;
      end
    join
    drain();
    down_ready = 0;
    send_m(8'hA1, 3'd1, 2'b00);
    send_m(8'hA2, 3'd2, 2'b01);
    send_m(8'hA3, 3'd3, 2'b10);
    rst_n = 0;
    sb.delete();
    tick(1);
    rst_n = 1;
    down_ready = 1;
    tick(4);
    check("flush_empty", 32'(down_valid), 0);
    send(8'hC3, 3'd2, 2'b11, 8'hF0);
    e0 = acc_cyc;
    tick(3);
    check("post_rst_lat", 32'(dv_hist[e0+2]), 1);
    drain();
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) send_m(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        done = 1;
      end
      begin
        while (!done) begin
          down_ready = $urandom_range(0, 3) != 0;
          tick(1);
        end
      end
    join
    down_ready = 1;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
